pnr_dac_pulse_driver: RTL

Output-side counterpart of the ADC input routing in the PNR path. It takes each photon-number result from the PNR discriminator and renders it as an analog pulse on one DAC channel. The pulse height is proportional to the photon number. A fixed-level marker pulse is driven on the other DAC channel at the same time. The block sits between the PNR result logic and the DAC output registers, and runs in the ADC clock domain.

---
 rtl/pnr_dac_pulse_driver_if.sv | 32 +++
 rtl/pnr_dac_pulse_driver.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pnr_dac_pulse_driver_if.sv
// Bundle between the PNR result logic and the DAC pulse driver.
// pnr_valid is a one-cycle strobe with no ready/backpressure: it is accepted
// only when the driver is idle, otherwise it is discarded and counted as a drop.
interface pnr_dac_pulse_driver_if #(
    parameter int PN_WIDTH  = 4,
    parameter int CNT_WIDTH = 16
);
    logic                        pnr_valid;
    logic [PN_WIDTH-1:0]         pnr_value;
    logic                        pnr_out_is_a;
    logic signed [13:0]          amp_step;
    logic signed [13:0]          marker_level;
    logic [CNT_WIDTH-1:0]        pulse_width;
    logic [CNT_WIDTH-1:0]        holdoff;
    logic                        drop_clr;
    logic signed [13:0]          dac_a;
    logic signed [13:0]          dac_b;
    logic                        busy;
    logic [CNT_WIDTH-1:0]        drop_count;

    modport master (
        output pnr_valid, pnr_value, pnr_out_is_a, amp_step, marker_level,
               pulse_width, holdoff, drop_clr,
        input  dac_a, dac_b, busy, drop_count
    );

    modport slave (
        input  pnr_valid, pnr_value, pnr_out_is_a, amp_step, marker_level,
               pulse_width, holdoff, drop_clr,
        output dac_a, dac_b, busy, drop_count
    );
endinterface

// File: rtl/pnr_dac_pulse_driver.sv
// Renders each photon-number result as a DAC pulse (height = n * amp_step)
// with a fixed marker pulse on the other channel, followed by optional hold-off.
module pnr_dac_pulse_driver #(
    parameter int PN_WIDTH  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pnr_dac_pulse_driver_if.slave  bus,
    output logic [1:0]             state_dbg
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam int PROD_W = PN_WIDTH + 15;
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(8191);
    localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-8192);

    state_t                 state, state_nxt;
    logic signed [PROD_W-1:0] prod;
    logic signed [13:0]     amp_sat;
    logic [CNT_WIDTH-1:0]   width_m1;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   hold_q;
    logic                   sel_a;
    logic signed [13:0]     amp_q;
    logic signed [13:0]     mark_q;
    logic                   accept;
    logic                   drop;
    logic signed [13:0]     dac_a_d;
    logic signed [13:0]     dac_b_d;
    logic                   busy_d;

    assign accept    = bus.pnr_valid && (state == ST_IDLE);
    assign drop      = bus.pnr_valid && (state != ST_IDLE);
    assign state_dbg = state;

    // Zero-extend the photon number so the product keeps the sign of amp_step.
    assign prod     = $signed({1'b0, bus.pnr_value}) * bus.amp_step;
    assign width_m1 = (bus.pulse_width == '0) ? '0 : bus.pulse_width - 1'b1;

    always_comb begin
        amp_sat = prod[13:0];
        if (prod > SAT_MAX) begin
            amp_sat = 14'sh1fff;
        end else if (prod < SAT_MIN) begin
            amp_sat = 14'sh2000;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.pnr_valid) state_nxt = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt == '0) state_nxt = (hold_q != '0) ? ST_HOLDOFF : ST_IDLE;
            end
            ST_HOLDOFF: begin
                if (cnt == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // One counter serves both phases: reloaded with holdoff-1 as the pulse ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            hold_q <= '0;
            sel_a  <= 1'b0;
            amp_q  <= '0;
            mark_q <= '0;
        end else if (accept) begin
            cnt    <= width_m1;
            hold_q <= bus.holdoff;
            sel_a  <= bus.pnr_out_is_a;
            amp_q  <= amp_sat;
            mark_q <= bus.marker_level;
        end else if (state == ST_PULSE && cnt == '0) begin
            cnt <= hold_q - 1'b1;
        end else if (state != ST_IDLE) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.drop_count <= '0;
        end else if (bus.drop_clr) begin
            bus.drop_count <= '0;
        end else if (drop && bus.drop_count != '1) begin
            bus.drop_count <= bus.drop_count + 1'b1;
        end
    end

    // Output logic: next output values, registered below.
    always_comb begin
        dac_a_d = '0;
        dac_b_d = '0;
        busy_d  = (state_nxt != ST_IDLE);
        if (state_nxt == ST_PULSE) begin
            if (accept) begin
                dac_a_d = bus.pnr_out_is_a ? amp_sat : bus.marker_level;
                dac_b_d = bus.pnr_out_is_a ? bus.marker_level : amp_sat;
            end else begin
                dac_a_d = sel_a ? amp_q : mark_q;
                dac_b_d = sel_a ? mark_q : amp_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dac_a <= '0;
            bus.dac_b <= '0;
            bus.busy  <= 1'b0;
        end else begin
            bus.dac_a <= dac_a_d;
            bus.dac_b <= dac_b_d;
            bus.busy  <= busy_d;
        end
    end
endmodule
